mem_bus_master: RTL and testbench

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

---
 rtl/mem_bus_master_pkg.sv | 53 +++++
 rtl/mem_lane_align.sv | 72 +++++++
 rtl/mem_bus_master.sv | 132 +++++++++++++
 tb/tb_mem_bus_master.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_master_pkg.sv
// Shared types for the MEM-stage bus master:
// op encodings, response codes, FSM states.
package mem_bus_master_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_SB  = 4'd5,
    OP_SH  = 4'd6,
    OP_SW  = 4'd7
  } op_e;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  function automatic logic op_legal(
    input logic [3:0] op
  );
    return op <= 4'd7;
  endfunction

  function automatic logic is_store(
    input logic [3:0] op
  );
    return op == OP_SB || op == OP_SH ||
           op == OP_SW;
  endfunction

  function automatic logic misaligned(
    input logic [3:0] op,
    input logic [1:0] a
  );
    logic half;
    logic word;
    half = op == OP_LH || op == OP_LHU ||
           op == OP_SH;
    word = op == OP_LW || op == OP_SW;
    return (half && a[0]) ||
           (word && a != 2'b00);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane logic: byte enables, store
// replication, load lane extraction and extension.
module mem_lane_align
  import mem_bus_master_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        sext;
  logic [7:0]  b;
  logic [15:0] h;

  assign is_byte = op == OP_LB || op == OP_LBU ||
                   op == OP_SB;
  assign is_half = op == OP_LH || op == OP_LHU ||
                   op == OP_SH;
  assign is_word = op == OP_LW || op == OP_SW;
  assign sext    = op == OP_LB || op == OP_LH;

  // Lane 0 (addr 00) is the most significant byte.
  always_comb begin
    b = 8'h00;
    unique case (addr_lo)
      2'b00: b = rdata[31:24];
      2'b01: b = rdata[23:16];
      2'b10: b = rdata[15:8];
      2'b11: b = rdata[7:0];
      default: b = 8'h00;
    endcase
    h = addr_lo[1] ? rdata[15:0]
                   : rdata[31:16];
  end

  always_comb begin
    sel       = 4'b0000;
    wdata_rep = 32'h0;
    rdata_ext = 32'h0;
    unique case (1'b1)
      is_byte: begin
        sel       = 4'b1000 >> addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sext & b[7]}}, b};
      end
      is_half: begin
        sel       = addr_lo[1] ? 4'b0011
                               : 4'b1100;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sext & h[15]}}, h};
      end
      is_word: begin
        sel       = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      default: begin
        sel       = 4'b0000;
        wdata_rep = 32'h0;
        rdata_ext = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_master.sv
// MEM-stage bus master: one load/store per
// IDLE -> ACCESS -> DONE pass over a simple RAM port.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state;
  logic [3:0]    op_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] wait_cnt;
  logic [3:0]    sel;
  logic [31:0]   wrep;
  logic [31:0]   rext;
  logic          access;
  logic          store;

  mem_lane_align u_align (
    .op        (op_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (ram_rdata),
    .sel       (sel),
    .wdata_rep (wrep),
    .rdata_ext (rext)
  );

  // RAM port decodes straight from state so reset
  // drops ram_ce without waiting for a clock.
  assign access    = state == S_ACCESS;
  assign store     = is_store(op_q);
  assign req_ready = state == S_IDLE;
  assign ram_ce    = access;
  assign ram_we    = access && store;
  assign ram_addr  = access ? {addr_q[31:2], 2'b00}
                            : 32'h0;
  assign ram_sel   = access ? sel : 4'b0000;
  assign ram_wdata = (access && store) ? wrep
                                       : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      op_q       <= 4'h0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wait_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= ERR_OK;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q     <= req_op;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            wait_cnt <= '0;
            if (!op_legal(req_op)) begin
              state      <= S_DONE;
              resp_valid <= 1'b1;
              resp_err   <= ERR_ILLEGAL;
              resp_rdata <= 32'h0;
            end else if (misaligned(req_op,
                           req_addr[1:0])) begin
              state      <= S_DONE;
              resp_valid <= 1'b1;
              resp_err   <= ERR_ALIGN;
              resp_rdata <= 32'h0;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (store) begin
            state      <= S_DONE;
            resp_valid <= 1'b1;
            resp_err   <= ERR_OK;
            resp_rdata <= 32'h0;
          end else if (ram_ready) begin
            state      <= S_DONE;
            resp_valid <= 1'b1;
            resp_err   <= ERR_OK;
            resp_rdata <= rext;
          end else if (wait_cnt ==
                       CW'(TIMEOUT - 1)) begin
            state      <= S_DONE;
            resp_valid <= 1'b1;
            resp_err   <= ERR_TIMEOUT;
            resp_rdata <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master: a word RAM
// model, expected responses queued at issue time.
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ready;

  int checks = 0;
  int errors = 0;

  logic [33:0] exp_q[$];
  logic [31:0] mem[16];
  logic        ready_en = 1'b1;
  int          ce_cnt = 0;
  int          ce_base = 0;
  logic [3:0]  last_sel;
  logic [31:0] last_wdata;
  logic [31:0] last_addr;
  logic        last_we;

  always #5 clk = ~clk;

  mem_bus_master #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_ce     (ram_ce),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_sel    (ram_sel),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_ready  (ram_ready)
  );

  assign ram_rdata = mem[ram_addr[5:2]];
  assign ram_ready = ram_ce && !ram_we && ready_en;

  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      if (ram_sel[3])
        mem[ram_addr[5:2]][31:24] <= ram_wdata[31:24];
      if (ram_sel[2])
        mem[ram_addr[5:2]][23:16] <= ram_wdata[23:16];
      if (ram_sel[1])
        mem[ram_addr[5:2]][15:8] <= ram_wdata[15:8];
      if (ram_sel[0])
        mem[ram_addr[5:2]][7:0] <= ram_wdata[7:0];
    end
  end

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ram_ce) begin
      ce_cnt++;
      last_sel   = ram_sel;
      last_wdata = ram_wdata;
      last_addr  = ram_addr;
      last_we    = ram_we;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got %h/%0d",
                 resp_rdata, resp_err);
      end else begin
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e[33:2]);
        chk("resp_err", {30'h0, resp_err},
            {30'h0, e[1:0]});
      end
    end
  end

  task automatic issue(
    input logic [3:0]  op,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [31:0] exp_d,
    input logic [1:0]  exp_e
  );
    bit done;
    done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    ce_base   = ce_cnt;
    exp_q.push_back({exp_d, exp_e});
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: op %0d", op);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    #12;
    chk("rst_req_ready", {31'h0, req_ready}, 1);
    chk("rst_ram_ce", {31'h0, ram_ce}, 0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    @(negedge clk);
    rst = 1'b1;

    issue(4'd7, 32'h10, 32'hAABBCCDD, 0, 0);
    chk("sw_ce_cycles", ce_cnt - ce_base, 1);
    chk("sw_sel", {28'h0, last_sel}, 32'hF);
    chk("sw_we", {31'h0, last_we}, 1);
    chk("sw_wdata", last_wdata, 32'hAABBCCDD);
    chk("sw_addr", last_addr, 32'h10);

    issue(4'd4, 32'h10, 0, 32'hAABBCCDD, 0);
    chk("lw_we", {31'h0, last_we}, 0);
    chk("lw_sel", {28'h0, last_sel}, 32'hF);

    issue(4'd5, 32'h13, 32'h80, 0, 0);
    chk("sb_sel", {28'h0, last_sel}, 32'h1);
    chk("sb_wdata", last_wdata, 32'h80808080);
    issue(4'd0, 32'h13, 0, 32'hFFFFFF80, 0);
    chk("lb_sel", {28'h0, last_sel}, 32'h1);
    issue(4'd1, 32'h13, 0, 32'h00000080, 0);

    issue(4'd2, 32'h21, 0, 0, 1);
    chk("lh_mis_ce", ce_cnt - ce_base, 0);

    issue(4'd3, 32'h12, 0, 32'h0000CC80, 0);
    issue(4'd2, 32'h10, 0, 32'hFFFFAABB, 0);
    issue(4'd0, 32'h11, 0, 32'hFFFFFFBB, 0);

    issue(4'd6, 32'h16, 32'hFFFF1234, 0, 0);
    chk("sh_sel", {28'h0, last_sel}, 32'h3);
    chk("sh_wdata", last_wdata, 32'h12341234);

    issue(4'd8, 32'h0, 0, 0, 3);
    chk("illegal_ce", ce_cnt - ce_base, 0);
    issue(4'd7, 32'h12, 0, 0, 1);
    chk("sw_mis_ce", ce_cnt - ce_base, 0);
    issue(4'd4, 32'h14, 0, 32'h00001234, 0);

    ready_en = 1'b0;
    issue(4'd4, 32'h10, 0, 0, 2);
    chk("timeout_cycles", ce_cnt - ce_base, 16);

    // Flush in the second ACCESS cycle
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 4'd4;
    req_addr  = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("flush_ce_pre", {31'h0, ram_ce}, 1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {31'h0, req_ready}, 1);
    chk("flush_ce", {31'h0, ram_ce}, 0);
    repeat (3) @(negedge clk);

    // Reset while a load waits on the RAM
    req_valid = 1'b1;
    req_op    = 4'd4;
    req_addr  = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_ce_pre", {31'h0, ram_ce}, 1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_ce", {31'h0, ram_ce}, 0);
    chk("rstmid_ready", {31'h0, req_ready}, 1);
    @(negedge clk);
    rst = 1'b1;
    ready_en = 1'b1;
    repeat (2) @(negedge clk);

    issue(4'd4, 32'h10, 0, 32'hAABBCC80, 0);
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
